execute_multicycle: RTL



---
 rtl/execute_multicycle_pkg.sv | 27 ++
 rtl/execute_multicycle_mc_queue.sv | 105 ++++++++++
 rtl/execute_multicycle.sv | 86 ++++++++
 3 files changed

// File: rtl/execute_multicycle_pkg.sv
// Shared types and constants for the multi-cycle completion unit.
package execute_multicycle_pkg;

  // Storage widths: unit field covers up to 16 units, data field up to XLEN=64.
  localparam int unsigned mc_unit_w = 4;
  localparam int unsigned mc_data_w = 64;
  localparam int unsigned mc_reg_w  = 5;

  // Functional unit indices.
  localparam int unsigned mc_unit_div = 0;
  localparam int unsigned mc_unit_mul = 1;

  typedef struct packed {
    logic                 valid;
    logic                 done;
    logic [mc_unit_w-1:0] unit;
    logic [mc_reg_w-1:0]  waddr;
    logic [mc_data_w-1:0] data;
  } mc_entry_type;

  function automatic mc_entry_type init_mc_entry();
    mc_entry_type e;
    e = '0;
    return e;
  endfunction

endpackage

// File: rtl/execute_multicycle_mc_queue.sv
// In-order completion queue: circular buffer with per-unit result capture.
module mc_queue
  import execute_multicycle_pkg::*;
#(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned UNITS = 2,
  parameter int unsigned DEPTH = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      clear_i,
  input  logic                      push_i,
  input  logic [mc_unit_w-1:0]      push_unit_i,
  input  logic [mc_reg_w-1:0]       push_waddr_i,
  input  logic [UNITS-1:0]          cap_valid_i,
  input  logic [UNITS*XLEN-1:0]     cap_data_i,
  input  logic                      pop_i,
  output logic                      head_valid_c,
  output logic                      head_done_c,
  output logic [mc_reg_w-1:0]       head_waddr_c,
  output logic [XLEN-1:0]           head_data_c,
  output logic [$clog2(DEPTH):0]    count_o,
  output logic [UNITS-1:0]          unit_busy_c,
  output logic [31:0]               busy_mask_c
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  mc_entry_type   q_q [DEPTH];
  mc_entry_type   q_d [DEPTH];
  logic [PW-1:0]  head_q, head_d;
  logic [PW-1:0]  tail_q, tail_d;
  logic [CW-1:0]  count_q, count_d;

  // Next state: capture, retire, allocate; flush overrides everything.
  always_comb begin
    q_d     = q_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    for (int e = 0; e < DEPTH; e++) begin
      for (int u = 0; u < UNITS; u++) begin
        if (cap_valid_i[u] && q_q[e].valid && !q_q[e].done &&
            q_q[e].unit == mc_unit_w'(u)) begin
          q_d[e].done = 1'b1;
          q_d[e].data = mc_data_w'(cap_data_i[u*XLEN +: XLEN]);
        end
      end
    end
    if (pop_i) begin
      q_d[head_q] = init_mc_entry();
      head_d      = head_q + PW'(1);
    end
    if (push_i) begin
      q_d[tail_q]       = init_mc_entry();
      q_d[tail_q].valid = 1'b1;
      q_d[tail_q].unit  = push_unit_i;
      q_d[tail_q].waddr = push_waddr_i;
      tail_d            = tail_q + PW'(1);
    end
    count_d = count_q + CW'(push_i) - CW'(pop_i);
    if (clear_i) begin
      for (int e = 0; e < DEPTH; e++) q_d[e] = init_mc_entry();
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int e = 0; e < DEPTH; e++) q_q[e] <= init_mc_entry();
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      q_q     <= q_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Status views derived from registered entries.
  always_comb begin
    head_valid_c = q_q[head_q].valid;
    head_done_c  = q_q[head_q].done;
    head_waddr_c = q_q[head_q].waddr;
    head_data_c  = XLEN'(q_q[head_q].data);
    count_o      = count_q;
    unit_busy_c  = '0;
    busy_mask_c  = '0;
    for (int e = 0; e < DEPTH; e++) begin
      for (int u = 0; u < UNITS; u++) begin
        if (q_q[e].valid && !q_q[e].done && q_q[e].unit == mc_unit_w'(u))
          unit_busy_c[u] = 1'b1;
      end
      if (q_q[e].valid) busy_mask_c[q_q[e].waddr] = 1'b1;
    end
    busy_mask_c[0] = 1'b0;
  end

endmodule

// File: rtl/execute_multicycle.sv
// Multi-cycle completion unit: issues to iterative units, retires in order.
module execute_multicycle
  import execute_multicycle_pkg::*;
#(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned UNITS    = 2,
  parameter int unsigned DEPTH    = 4,
  parameter bit          BLOCKING = 1'b0
) (
  input  logic                                         clk,
  input  logic                                         rst,
  input  logic                                         issue_valid,
  input  logic [((UNITS > 1) ? $clog2(UNITS) : 1)-1:0] issue_unit,
  input  logic [4:0]                                   issue_waddr,
  output logic                                         issue_ready,
  output logic                                         stall,
  input  logic                                         clear,
  output logic [UNITS-1:0]                             unit_enable,
  output logic [UNITS-1:0]                             unit_kill,
  input  logic [UNITS-1:0]                             unit_ready,
  input  logic [UNITS*XLEN-1:0]                        unit_result,
  output logic                                         wb_wren,
  output logic [4:0]                                   wb_waddr,
  output logic [XLEN-1:0]                              wb_wdata,
  output logic [31:0]                                  busy_mask
);

  localparam int unsigned UW = (UNITS > 1) ? $clog2(UNITS) : 1;
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic                head_valid, head_done;
  logic [mc_reg_w-1:0] head_waddr;
  logic [XLEN-1:0]     head_data;
  logic [CW-1:0]       count;
  logic [UNITS-1:0]    unit_busy;
  logic                unit_free, push, pop;

  // Issue handshake from registered queue state; flush blocks issue.
  always_comb begin
    unit_free = 1'b0;
    for (int u = 0; u < UNITS; u++) begin
      if (issue_unit == UW'(u)) unit_free = ~unit_busy[u];
    end
    issue_ready = ~clear & (count < CW'(DEPTH)) & unit_free &
                  (~BLOCKING | (count == '0));
    push        = issue_valid & issue_ready;
    stall       = issue_valid & ~issue_ready;
    unit_enable = '0;
    for (int u = 0; u < UNITS; u++) begin
      unit_enable[u] = push & (issue_unit == UW'(u));
    end
    unit_kill = {UNITS{clear}} & unit_busy;
  end

  // Retire the head once its result was captured in an earlier cycle.
  always_comb begin
    pop      = head_valid & head_done & ~clear;
    wb_wren  = pop & (|head_waddr);
    wb_waddr = pop ? head_waddr : '0;
    wb_wdata = pop ? head_data : '0;
  end

  mc_queue #(
    .XLEN  (XLEN),
    .UNITS (UNITS),
    .DEPTH (DEPTH)
  ) u_queue (
    .clk          (clk),
    .rst          (rst),
    .clear_i      (clear),
    .push_i       (push),
    .push_unit_i  (mc_unit_w'(issue_unit)),
    .push_waddr_i (issue_waddr),
    .cap_valid_i  (unit_ready),
    .cap_data_i   (unit_result),
    .pop_i        (pop),
    .head_valid_c (head_valid),
    .head_done_c  (head_done),
    .head_waddr_c (head_waddr),
    .head_data_c  (head_data),
    .count_o      (count),
    .unit_busy_c  (unit_busy),
    .busy_mask_c  (busy_mask)
  );

endmodule
